dpa_arbiter: RTL and testbench
==============================

DPA_ARBITER -- requirements
Module: dpa_arbiter

Interface
REQ-001 Parameter: GRANT_REG, default 1, selects grant timing (1 = grant registered on clk; 0 = grant combinational).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 north  input  1  availability token from the cell above; 1 = output column still free.
REQ-005 west  input  1  availability token from the cell to the left; 1 = input row still free.
REQ-006 request  input  1  this cell's input/output pair is requested.
REQ-007 mask  input  1  priority-diagonal marker; 1 = this cell is on the top-priority diagonal.
REQ-008 south  output  1  token passed to the cell below; 1 = column still free.
REQ-009 east  output  1  token passed to the cell to the right; 1 = row still free.
REQ-010 grant  output  1  request granted for this cell.

Function
REQ-011 The block SHALL form effective tokens eff_n = north | mask and eff_w = west | mask.
REQ-012 The block SHALL compute the grant condition gnt_c = request & eff_n & eff_w.
REQ-013 south SHALL equal eff_n & ~gnt_c, combinational, with zero cycles of latency, so tokens ripple through an array within one cycle.
REQ-014 east SHALL equal eff_w & ~gnt_c, combinational, with zero cycles of latency.
REQ-015 With GRANT_REG=1, grant SHALL be a flop loaded with gnt_c on every rising clk edge, giving one cycle of latency.
REQ-016 With GRANT_REG=0, grant SHALL equal gnt_c combinationally.
REQ-017 With mask=1, north and west SHALL be ignored: south = east = ~request and gnt_c = request.
REQ-018 With mask=0 and north=0, gnt_c SHALL be 0, south SHALL be 0 and east SHALL equal west.
REQ-019 With mask=0 and west=0, gnt_c SHALL be 0, east SHALL be 0 and south SHALL equal north.
REQ-020 south and east SHALL never both be 1 while gnt_c=1; at most one grant is consumed per token pair.
REQ-021 A change of mask SHALL take effect on south and east in the same cycle.
REQ-022 A change of mask SHALL take effect on grant at the next edge when GRANT_REG=1.
REQ-023 The block SHALL contain no other state.

Reset
REQ-024 rst_n=0 SHALL force the registered grant to 0 immediately, without waiting for a clock edge.
REQ-025 While rst_n=0 the registered grant SHALL stay 0.
REQ-026 rst_n=0 SHALL NOT affect south or east; these stay combinational functions of the inputs.
REQ-027 After rst_n deasserts, the first rising edge SHALL load gnt_c into grant.
REQ-028 Reset asserted mid-grant SHALL clear grant asynchronously.
REQ-029 The cleared grant SHALL reload at the first edge after release if gnt_c is still 1.

Verification
REQ-030 Priority grant: mask=1, north=1, west=1, request=1 -> south=0 and east=0 at once; grant=1 after the next edge.
REQ-031 Priority pass-through and override: mask=1, request=0 -> south=1, east=1, grant=0; then mask=1, north=0, west=1, request=1 -> grant=1, south=0, east=0.
REQ-032 Normal cell: mask=0, north=1, west=1, request=1 -> grant=1, south=0, east=0; then request=0 -> grant=0, south=1, east=1.
REQ-033 Blocked column: mask=0, north=0, west=1, request=1 -> grant=0, south=0, east=1.
REQ-034 Blocked row: mask=0, north=1, west=0, request=1 -> grant=0, south=1, east=0.
REQ-035 Reset: with grant=1, drive rst_n=0 between edges -> grant=0 immediately and south/east unchanged; release with gnt_c=1 -> grant=1 after the next edge.

Source files
------------

// File: rtl/dpa_arbiter.sv
// rtl/dpa_arbiter.sv - diagonal-priority crossbar arbiter cell with token ripple
// Tokens flow north->south and west->east; a cell on the priority diagonal regenerates both.
module dpa_arbiter #(
    parameter int GRANT_REG = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic north,
    input  logic west,
    input  logic request,
    input  logic mask,
    output logic south,
    output logic east,
    output logic grant
);

    logic eff_n;
    logic eff_w;
    logic gnt_c;

    // The diagonal cell behaves as if both tokens arrived, which breaks the ring in the array.
    assign eff_n = north | mask;
    assign eff_w = west  | mask;
    assign gnt_c = request & eff_n & eff_w;

    // A grant consumes both tokens, so the row and column are closed downstream.
    assign south = eff_n & ~gnt_c;
    assign east  = eff_w & ~gnt_c;

    generate
        if (GRANT_REG != 0) begin : g_reg
            logic grant_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    grant_q <= 1'b0;
                end else begin
                    grant_q <= gnt_c;
                end
            end

            assign grant = grant_q;
        end else begin : g_comb
            assign grant = gnt_c;
        end
    endgenerate

endmodule

// File: tb/tb_dpa_arbiter.sv
// tb/tb_dpa_arbiter.sv - directed self-checking bench for dpa_arbiter
module tb_dpa_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    logic north, west, request, mask;
    logic south_r, east_r, grant_r;
    logic south_c, east_c, grant_c;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dpa_arbiter #(.GRANT_REG(1)) u_reg (
        .clk(clk), .rst_n(rst_n), .north(north), .west(west),
        .request(request), .mask(mask),
        .south(south_r), .east(east_r), .grant(grant_r)
    );

    dpa_arbiter #(.GRANT_REG(0)) u_comb (
        .clk(clk), .rst_n(rst_n), .north(north), .west(west),
        .request(request), .mask(mask),
        .south(south_c), .east(east_c), .grant(grant_c)
    );

    task automatic drive(input logic m, input logic n, input logic w, input logic r);
        @(negedge clk);
        mask = m; north = n; west = w; request = r;
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        @(posedge clk); #1;
        total++;
        if (grant_r !== 1'b0) begin
            bad++; $display("FAIL reset_hold grant got=%b exp=0", grant_r);
        end
        total++;
        if ({south_r, east_r} !== 2'b00) begin
            bad++; $display("FAIL reset_comb south/east got=%b exp=00", {south_r, east_r});
        end
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        rst_n = 1'b1;
        #1;
        total++;
        if ({south_r, east_r, grant_r} !== 3'b110) begin
            bad++; $display("FAIL reset_release s/e/g got=%b exp=110", {south_r, east_r, grant_r});
        end
    endtask

    task automatic test_priority_grant;
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        total++;
        if ({south_r, east_r, grant_r} !== 3'b000) begin
            bad++; $display("FAIL prio_grant_now s/e/g got=%b exp=000", {south_r, east_r, grant_r});
        end
        total++;
        if (grant_c !== 1'b1) begin
            bad++; $display("FAIL prio_grant_comb got=%b exp=1", grant_c);
        end
        @(posedge clk); #1;
        total++;
        if (grant_r !== 1'b1) begin
            bad++; $display("FAIL prio_grant_edge got=%b exp=1", grant_r);
        end
    endtask

    task automatic test_priority_pass;
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        @(posedge clk); #1;
        total++;
        if ({south_r, east_r, grant_r} !== 3'b110) begin
            bad++; $display("FAIL prio_pass s/e/g got=%b exp=110", {south_r, east_r, grant_r});
        end
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        @(posedge clk); #1;
        total++;
        if ({south_r, east_r, grant_r} !== 3'b001) begin
            bad++; $display("FAIL prio_override s/e/g got=%b exp=001", {south_r, east_r, grant_r});
        end
    endtask

    task automatic test_normal;
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        @(posedge clk); #1;
        total++;
        if ({south_r, east_r, grant_r} !== 3'b001) begin
            bad++; $display("FAIL normal_grant s/e/g got=%b exp=001", {south_r, east_r, grant_r});
        end
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        @(posedge clk); #1;
        total++;
        if ({south_r, east_r, grant_r} !== 3'b110) begin
            bad++; $display("FAIL normal_idle s/e/g got=%b exp=110", {south_r, east_r, grant_r});
        end
    endtask

    task automatic test_blocked;
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        @(posedge clk); #1;
        total++;
        if ({south_r, east_r, grant_r} !== 3'b010) begin
            bad++; $display("FAIL blocked_col s/e/g got=%b exp=010", {south_r, east_r, grant_r});
        end
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        @(posedge clk); #1;
        total++;
        if ({south_r, east_r, grant_r} !== 3'b100) begin
            bad++; $display("FAIL blocked_row s/e/g got=%b exp=100", {south_r, east_r, grant_r});
        end
    endtask

    task automatic test_mask_change;
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        total++;
        if ({south_r, east_r, grant_r} !== 3'b000) begin
            bad++; $display("FAIL mask_same_cycle s/e/g got=%b exp=000", {south_r, east_r, grant_r});
        end
        @(posedge clk); #1;
        total++;
        if (grant_r !== 1'b1) begin
            bad++; $display("FAIL mask_next_edge grant got=%b exp=1", grant_r);
        end
    endtask

    // Index is {mask, north, west, request}; entry is {gnt_c, south, east}.
    task automatic test_truth_table;
        logic [2:0] exp_tab [16];
        logic [3:0] v;
        exp_tab = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b010, 3'b010, 3'b011, 3'b100,
                    3'b011, 3'b100, 3'b011, 3'b100, 3'b011, 3'b100, 3'b011, 3'b100};
        for (int i = 0; i < 16; i++) begin
            v = 4'(i);
            drive(v[3], v[2], v[1], v[0]);
            total++;
            if ({grant_c, south_c, east_c} !== exp_tab[i]) begin
                bad++; $display("FAIL table_comb idx=%0d g/s/e got=%b exp=%b", i, {grant_c, south_c, east_c}, exp_tab[i]);
            end
            total++;
            if ({south_r, east_r} !== exp_tab[i][1:0]) begin
                bad++; $display("FAIL table_reg_se idx=%0d got=%b exp=%b", i, {south_r, east_r}, exp_tab[i][1:0]);
            end
            @(posedge clk); #1;
            total++;
            if (grant_r !== exp_tab[i][2]) begin
                bad++; $display("FAIL table_reg_g idx=%0d got=%b exp=%b", i, grant_r, exp_tab[i][2]);
            end
        end
    endtask

    task automatic test_async_reset;
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        @(posedge clk); #1;
        total++;
        if (grant_r !== 1'b1) begin
            bad++; $display("FAIL areset_pre grant got=%b exp=1", grant_r);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (grant_r !== 1'b0) begin
            bad++; $display("FAIL areset_immediate grant got=%b exp=0", grant_r);
        end
        total++;
        if ({south_r, east_r, grant_c} !== 3'b001) begin
            bad++; $display("FAIL areset_comb s/e/gc got=%b exp=001", {south_r, east_r, grant_c});
        end
        @(posedge clk); #1;
        total++;
        if (grant_r !== 1'b0) begin
            bad++; $display("FAIL areset_hold grant got=%b exp=0", grant_r);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (grant_r !== 1'b0) begin
            bad++; $display("FAIL areset_release_noedge grant got=%b exp=0", grant_r);
        end
        @(posedge clk); #1;
        total++;
        if (grant_r !== 1'b1) begin
            bad++; $display("FAIL areset_reload grant got=%b exp=1", grant_r);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        mask = 1'b0; north = 1'b0; west = 1'b0; request = 1'b0;
        test_reset;
        test_priority_grant;
        test_priority_pass;
        test_normal;
        test_blocked;
        test_mask_change;
        test_truth_table;
        test_async_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
